// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the ALU serial link: packet framing constants, the
// transmitter state encoding, flag/error bit positions and the CRC helpers.
package mtm_alu_pkg;

    localparam int   PKT_BITS     = 11;
    localparam logic PKT_DATA     = 1'b0;
    localparam logic PKT_CMD      = 1'b1;
    localparam logic START_BIT    = 1'b0;
    localparam logic STOP_BIT     = 1'b1;
    localparam int   CRC_MSG_BITS = 37;

    localparam int FLAG_CARRY = 3;
    localparam int FLAG_OVFL  = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_NEG   = 0;

    localparam int ERR_DATA = 2;
    localparam int ERR_CRC  = 1;
    localparam int ERR_OP   = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_DATA = 2'd1,
        SEND_CTL  = 2'd2,
        SEND_ERR  = 2'd3
    } tx_state_e;

    // Serial CRC, polynomial x^3+x+1, zero init, MSB of the message fed first.
    function automatic logic [2:0] crc3(input logic [CRC_MSG_BITS-1:0] msg);
        logic [2:0] crc;
        logic       fb;
        crc = 3'b000;
        for (int i = CRC_MSG_BITS - 1; i >= 0; i--) begin
            fb  = crc[2] ^ msg[i];
            crc = {crc[1], crc[0] ^ fb, fb};
        end
        return crc;
    endfunction

    // Error payload: marker bit, code twice, then a bit forcing even parity.
    function automatic logic [7:0] err_payload(input logic [2:0] err);
        logic [2:0] code;
        code = {err[ERR_DATA], err[ERR_CRC], err[ERR_OP]};
        return {1'b1, code, code, ^{1'b1, code, code}};
    endfunction

endpackage

// File: rtl/mtm_alu_pkt_tx.sv
// Single 11-bit packet shifter: start bit, type, 8 payload bits MSB first, stop.
// A load on the edge that ends a stop bit chains the next packet with no gap.
module mtm_alu_pkt_tx
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       type_i,
    input  logic [7:0] byte_i,
    output logic       sout_bit_o,
    output logic       last_bit_o
);

    localparam logic [3:0] LAST_IDX = 4'(PKT_BITS - 1);

    logic                active_q,  active_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [PKT_BITS-2:0] shift_q,   shift_d;
    logic                sout_q,    sout_d;
    logic                at_last;

    assign at_last = active_q && (bit_cnt_q >= LAST_IDX);

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        active_d  = active_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sout_d    = STOP_BIT;
        if (load_i) begin
            active_d  = 1'b1;
            bit_cnt_d = '0;
            shift_d   = {type_i, byte_i, STOP_BIT};
            sout_d    = START_BIT;
        end else if (at_last) begin
            active_d  = 1'b0;
            bit_cnt_d = '0;
        end else if (active_q) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            sout_d    = shift_q[PKT_BITS-2];
            shift_d   = {shift_q[PKT_BITS-3:0], STOP_BIT};
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q  <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            sout_q    <= 1'b1;
        end else begin
            active_q  <= active_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sout_q    <= sout_d;
        end
    end

    assign sout_bit_o = sout_q;
    assign last_bit_o = at_last;

endmodule

// File: rtl/mtm_alu_serializer.sv
// Transmit end of the ALU serial link: sequences DATA packets, then a CTL packet
// with flags and CRC, or a single error packet, through the packet shifter.
module mtm_alu_serializer
    import mtm_alu_pkg::*;
#(
    parameter int DATA_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_err,
    input  logic [DATA_BYTES*8-1:0] in_c,
    input  logic [3:0]            in_flags,
    input  logic [2:0]            in_err_flags,
    output logic                  sout,
    output logic                  busy
);

    localparam int              C_W       = DATA_BYTES * 8;
    localparam int              BC_W      = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(DATA_BYTES - 1);

    tx_state_e       state_q,    state_d;
    logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [C_W-1:0]  c_q,        c_d;
    logic [3:0]      flags_q,    flags_d;
    logic            rdy_q;

    logic       accept;
    logic       load;
    logic       pkt_type;
    logic [7:0] pkt_byte;
    logic [7:0] ctl_byte;
    logic       last_bit;
    logic       tx_bit;

    assign accept   = in_valid && rdy_q;
    assign ctl_byte = {1'b0, flags_q[FLAG_CARRY], flags_q[FLAG_OVFL], flags_q[FLAG_ZERO],
                       flags_q[FLAG_NEG], crc3({c_q, 1'b0, flags_q})};

    // The first packet is loaded straight from the inputs on the accept edge so
    // its start bit leaves in the very next cycle; later packets use the captures.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        c_d        = c_q;
        flags_d    = flags_q;
        load       = 1'b0;
        pkt_type   = PKT_DATA;
        pkt_byte   = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    c_d        = in_c;
                    flags_d    = in_flags;
                    byte_cnt_d = '0;
                    load       = 1'b1;
                    if (in_err) begin
                        state_d  = SEND_ERR;
                        pkt_type = PKT_CMD;
                        pkt_byte = err_payload(in_err_flags);
                    end else begin
                        state_d  = SEND_DATA;
                        pkt_byte = in_c[C_W-1 -: 8];
                    end
                end
            end
            SEND_DATA: begin
                if (last_bit) begin
                    load = 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d    = SEND_CTL;
                        byte_cnt_d = '0;
                        pkt_type   = PKT_CMD;
                        pkt_byte   = ctl_byte;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                        pkt_byte   = c_q[C_W-1-8*int'(byte_cnt_d) -: 8];
                    end
                end
            end
            SEND_CTL, SEND_ERR: begin
                if (last_bit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                byte_cnt_d = '0;
            end
        endcase
    end

    // Ready is registered so it rises only on the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            c_q        <= '0;
            flags_q    <= '0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            c_q        <= c_d;
            flags_q    <= flags_d;
            rdy_q      <= (state_d == IDLE);
        end
    end

    mtm_alu_pkt_tx u_pkt_tx (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .type_i     (pkt_type),
        .byte_i     (pkt_byte),
        .sout_bit_o (tx_bit),
        .last_bit_o (last_bit)
    );

    assign sout     = tx_bit;
    assign in_ready = rdy_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/mtm_alu_serializer.md
Name: mtm_alu_serializer

Overview:
Transmit end of the ALU serial link. It takes one ALU result (32-bit C plus flags) or an error code and shifts it out on a single line in the same 11-bit packet framing the input deserializer accepts:
- start bit 0
- type bit (0 = DATA, 1 = CMD)
- 8 payload bits, MSB first
- stop bit 1

It sits between the ALU core and the `sout` pin and computes the outgoing CRC itself.

Parameters:
- DATA_BYTES, 4, number of DATA packets per result; C width = DATA_BYTES*8.
- PKT_BITS, 11, bits per packet; fixed and not to be overridden.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request to send; accepted only when in_ready=1.
- in_ready  out  1  serializer idle, can accept a request.
- in_err  in  1  1 = send error packet, 0 = send result.
- in_c  in  32  ALU result C.
- in_flags  in  4  {Carry, Overflow, Zero, Negative}.
- in_err_flags  in  3  error code {ERR_DATA, ERR_CRC, ERR_OP}.
- sout  out  1  serial output; idles high.
- busy  out  1  frame in progress (inverse of in_ready).

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - sout=1, in_ready=0 while rst=1, busy=0, state=IDLE, counters=0, shift regs=0.
  - An in-progress frame is aborted and never resumed.
  - in_ready=1 from the first clk edge after rst deasserts.
- States: IDLE, SEND_DATA, SEND_CTL, SEND_ERR.
- IDLE:
  - sout=1, in_ready=1.
  - On an edge with in_valid=1, capture all inputs into internal registers.
  - Go to SEND_ERR if in_err=1, else SEND_DATA. Later input changes are ignored until the next accept.
- Output timing:
  - sout is registered.
  - The start bit appears in the cycle after the accept edge; exactly one bit per clk.
- Packet bit order: bit_cnt 0..10 → 0, type, payload[7] … payload[0], 1.
- SEND_DATA:
  - Sends DATA_BYTES packets, type=0, payload = C bytes MSB byte first (C[31:24] first).
  - byte_cnt increments when bit_cnt wraps 10→0.
  - After the last DATA stop bit, go directly to SEND_CTL with no gap.
- SEND_CTL:
  - One packet, type=1, payload = {1'b0, flags[3:0], crc3[2:0]}.
  - crc3: polynomial x^3+x+1, init 3'b000, computed over the 37-bit message {C[31:0], 1'b0, flags[3:0]}, MSB fed first.
  - crc3 is computed combinationally from the captured registers.
- SEND_ERR:
  - One packet, type=1, payload = {1'b1, err[2:0], err[2:0], p}.
  - p is chosen so the 8-bit payload has even parity.
- Frame length:
  - Result frame: 55 bits (busy for 55 cycles).
  - Error frame: 11 bits.
- End of frame:
  - Return to IDLE on the edge ending the final stop bit.
  - in_ready=1 in the following cycle, so at least one idle-high cycle separates frames.
- in_valid while busy is ignored; not queued, no error.
- Counters:
  - bit_cnt is 4-bit, 0..10, wraps to 0.
  - byte_cnt is 2-bit for DATA_BYTES=4 (width $clog2(DATA_BYTES)).
  - No other values are reachable. An illegal state recovers to IDLE with sout=1.

Decomposition:
- Shared package mtm_alu_pkg:
  - packet type constants (DATA=1'b0, CMD=1'b1), START/STOP bit values, PKT_BITS.
  - state enum, flag bit indices, err_flag bit indices.
  - crc3 function (polynomial x^3+x+1, 37-bit data), so the deserializer's response model can reuse it.
- One sub-module is natural: mtm_alu_pkt_tx, an 11-bit packet shifter.
  - Inputs: load, type, byte.
  - Outputs: sout_bit, last_bit.
  - The top-level FSM sequences packets through it.

Test Plan:
- Reset: assert rst mid-frame (cycle 20 of a result frame) → sout=1 immediately and stays high; in_ready=1 one cycle after release; next request transmits a fresh full frame.
- Zero result: in_c=0x00000000, in_flags=4'b0000 → 4 packets 0_0_00000000_1, then CTL packet 0_1_00000000_1 (CTL=0x00); 55 cycles busy.
- Data order and CRC: in_c=0x12345678, in_flags=4'b0000 → first packet 0_0_00010010_1, then payloads 0x34, 0x56, 0x78 in order; CTL payload equals the reference-model crc3 value. Separately, in_c=0, in_flags=4'b0010 → CTL payload 0x16 (crc3=3'b110).
- Error packets: in_err=1, err=3'b100 → single packet 0_1_11001001_1 (0xC9), busy 11 cycles; err=3'b010 → payload 0xA5.
- Handshake: hold in_valid=1 continuously with changing in_c → each frame carries the value present at its accept edge; in_valid while busy is never captured; exactly one sout=1 idle cycle between frames.
- Back-to-back mix (result, error, result) → frame lengths 55/11/55; no dropped or duplicated bits; sout never 0 outside frames.
